// File: rtl/ps2_host_transmitter_if.sv
// Host-side command byte handshake for the PS/2 transmitter.
// The master offers a byte with tx_valid/tx_data; the slave (transmitter)
// reports readiness and the outcome of each transfer.
interface ps2_host_transmitter_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       tx_done;
  logic       tx_ack_ok;
  logic       tx_error;

  modport master (
    output tx_data, tx_valid,
    input  tx_ready, tx_done, tx_ack_ok, tx_error
  );

  modport slave (
    input  tx_data, tx_valid,
    output tx_ready, tx_done, tx_ack_ok, tx_error
  );
endinterface

// File: rtl/ps2_host_transmitter.sv
// Host-to-device PS/2 transmitter. Inhibits the bus by holding the PS/2
// clock low, issues a request-to-send (data low, clock released), then
// shifts the byte, odd parity and stop bit out on the keyboard's falling
// clock edges and samples the device's ack bit. A timeout aborts a transfer
// if the keyboard stops clocking. All outputs are registered; the
// asynchronous reset releases both open-drain lines immediately.
module ps2_host_transmitter #(
  parameter int unsigned INHIBIT_CYCLES = 10_000,
  parameter int unsigned TIMEOUT_CYCLES = 2_000_000
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         ps2_clk_i,
  input  logic                         ps2_data_i,
  ps2_host_transmitter_if.slave        tx_if,
  output logic                         ps2_clk_drive_low_o,
  output logic                         ps2_data_drive_low_o,
  output logic                         rx_inhibit_o
);

  localparam int INH_W = $clog2(INHIBIT_CYCLES + 1);
  localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);
  // Data goes low one cycle before the clock is released, so both lines
  // are low together on the final inhibit cycle.
  localparam logic [INH_W-1:0] INH_DATA = INH_W'(INHIBIT_CYCLES - 2);
  localparam logic [INH_W-1:0] INH_LAST = INH_W'(INHIBIT_CYCLES - 1);
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_INHIBIT,
    ST_REQUEST,
    ST_WAIT_ACK,
    ST_WAIT_IDLE
  } state_t;

  state_t           state_q;
  logic             clk_s0_q, clk_s1_q, clk_prev_q;
  logic             data_s0_q, data_s1_q;
  logic [9:0]       shift_q;
  logic [3:0]       bit_idx_q;
  logic [INH_W-1:0] inh_cnt_q;
  logic [TO_W-1:0]  to_cnt_q;
  logic             ack_q;
  logic             tx_ready_q, clk_low_q, data_low_q, inhibit_q;
  logic             done_q, ack_ok_q, error_q;
  logic             clk_fall;
  logic             to_hit;

  assign clk_fall = clk_prev_q & ~clk_s1_q;
  assign to_hit   = (to_cnt_q == TO_LAST);

  // Two-flop synchronisers for the raw pins plus a delayed copy of the
  // synchronised clock for falling-edge detection; idle-high after reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clk_s0_q   <= 1'b1;
      clk_s1_q   <= 1'b1;
      clk_prev_q <= 1'b1;
      data_s0_q  <= 1'b1;
      data_s1_q  <= 1'b1;
    end else begin
      clk_s0_q   <= ps2_clk_i;
      clk_s1_q   <= clk_s0_q;
      clk_prev_q <= clk_s1_q;
      data_s0_q  <= ps2_data_i;
      data_s1_q  <= data_s0_q;
    end
  end

  // Transfer sequencer: inhibit, request, shift on keyboard edges, ack, idle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      shift_q    <= '0;
      bit_idx_q  <= '0;
      inh_cnt_q  <= '0;
      to_cnt_q   <= '0;
      ack_q      <= 1'b0;
      tx_ready_q <= 1'b1;
      clk_low_q  <= 1'b0;
      data_low_q <= 1'b0;
      inhibit_q  <= 1'b0;
      done_q     <= 1'b0;
      ack_ok_q   <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      done_q  <= 1'b0;
      error_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (tx_if.tx_valid) begin
            // Frame bits in shift order: d0..d7, odd parity, stop.
            shift_q    <= {1'b1, ~^tx_if.tx_data, tx_if.tx_data};
            bit_idx_q  <= '0;
            inh_cnt_q  <= '0;
            to_cnt_q   <= '0;
            ack_q      <= 1'b0;
            ack_ok_q   <= 1'b0;
            tx_ready_q <= 1'b0;
            inhibit_q  <= 1'b1;
            clk_low_q  <= 1'b1;
            state_q    <= ST_INHIBIT;
          end
        end
        ST_INHIBIT: begin
          inh_cnt_q <= inh_cnt_q + 1'b1;
          if (inh_cnt_q == INH_DATA) begin
            data_low_q <= 1'b1;
          end
          if (inh_cnt_q == INH_LAST) begin
            clk_low_q <= 1'b0;
            state_q   <= ST_REQUEST;
          end
        end
        ST_REQUEST, ST_WAIT_ACK, ST_WAIT_IDLE: begin
          if (to_hit) begin
            clk_low_q  <= 1'b0;
            data_low_q <= 1'b0;
            error_q    <= 1'b1;
            tx_ready_q <= 1'b1;
            inhibit_q  <= 1'b0;
            state_q    <= ST_IDLE;
          end else begin
            to_cnt_q <= to_cnt_q + 1'b1;
            if (state_q == ST_REQUEST) begin
              if (clk_fall) begin
                data_low_q <= ~shift_q[bit_idx_q];
                bit_idx_q  <= bit_idx_q + 1'b1;
                if (bit_idx_q == 4'd9) begin
                  state_q <= ST_WAIT_ACK;
                end
              end
            end else if (state_q == ST_WAIT_ACK) begin
              if (clk_fall) begin
                ack_q   <= ~data_s1_q;
                state_q <= ST_WAIT_IDLE;
              end
            end else begin
              if (clk_s1_q && data_s1_q) begin
                done_q     <= 1'b1;
                ack_ok_q   <= ack_q;
                tx_ready_q <= 1'b1;
                inhibit_q  <= 1'b0;
                state_q    <= ST_IDLE;
              end
            end
          end
        end
        default: begin
          clk_low_q  <= 1'b0;
          data_low_q <= 1'b0;
          tx_ready_q <= 1'b1;
          inhibit_q  <= 1'b0;
          state_q    <= ST_IDLE;
        end
      endcase
    end
  end

  assign tx_if.tx_ready       = tx_ready_q;
  assign tx_if.tx_done        = done_q;
  assign tx_if.tx_ack_ok      = ack_ok_q;
  assign tx_if.tx_error       = error_q;
  assign ps2_clk_drive_low_o  = clk_low_q;
  assign ps2_data_drive_low_o = data_low_q;
  assign rx_inhibit_o         = inhibit_q;

endmodule

// File: tb/tb_ps2_host_transmitter.sv
// Bench for ps2_host_transmitter: a behavioural keyboard drives the
// open-drain bus and records each frame; a scoreboard of expected frames
// and outcomes is filled by the stimulus and drained by monitors.
module tb_ps2_host_transmitter;
  localparam int INH    = 20;
  localparam int TO     = 5000;
  localparam int HALF   = 20;
  localparam int M_ACK    = 0;
  localparam int M_NACK   = 1;
  localparam int M_SILENT = 2;

  typedef struct packed {
    logic is_err;
    logic ack;
  } out_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  ps2_host_transmitter_if bus ();
  logic clk_drive_low, data_drive_low, rx_inhibit;
  logic dev_clk_low = 1'b0;
  logic dev_data_low = 1'b0;
  logic ps2_clk_line, ps2_data_line;
  assign ps2_clk_line  = ~(clk_drive_low | dev_clk_low);
  assign ps2_data_line = ~(data_drive_low | dev_data_low);

  ps2_host_transmitter #(
    .INHIBIT_CYCLES(INH),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk                 (clk),
    .rst                 (rst),
    .ps2_clk_i           (ps2_clk_line),
    .ps2_data_i          (ps2_data_line),
    .tx_if               (bus),
    .ps2_clk_drive_low_o (clk_drive_low),
    .ps2_data_drive_low_o(data_drive_low),
    .rx_inhibit_o        (rx_inhibit)
  );

  out_t        exp_out[$];
  logic [10:0] exp_frame[$];
  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int n_acc    = 0;
  int exp_acc  = 0;
  int dev_mode = M_ACK;
  int dev_state = 0;
  int dev_bit   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
  endtask

  task automatic fail_evt(input string name);
    n_checks++;
    $display("FAIL %s: event occurred, none required", name);
  endtask

  // Reference model: frame is start 0, data LSB first, odd parity, stop 1.
  task automatic expect_xfer(input logic [7:0] b, input int mode);
    out_t e;
    logic par;
    par = (($countones(b) % 2) == 0);
    if (mode != M_SILENT) exp_frame.push_back({1'b1, par, b, 1'b0});
    e.is_err = (mode == M_SILENT);
    e.ack    = (mode == M_ACK);
    exp_out.push_back(e);
    exp_acc++;
    $display("txn: byte=0x%02h mode=%0d", b, mode);
  endtask

  task automatic send(input logic [7:0] b, input int hold);
    int w;
    w = 0;
    @(negedge clk);
    while (!bus.tx_ready && w < 10000) begin
      @(negedge clk);
      w++;
    end
    if (w >= 10000) fail_evt("ready_wait_timeout");
    bus.tx_data  = b;
    bus.tx_valid = 1'b1;
    repeat (hold) @(negedge clk);
    bus.tx_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int w;
    w = 0;
    while ((exp_out.size() != 0 || exp_frame.size() != 0) && w < 8000) begin
      @(negedge clk);
      w++;
    end
    if (w >= 8000) fail_evt("drain_timeout");
    repeat (2) @(negedge clk);
  endtask

  // Keyboard model: clocks the frame after a request, samples on rising edges.
  initial begin
    int dcnt;
    logic [10:0] bits;
    dcnt = 0;
    bits = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        dev_state = 0; dcnt = 0; dev_clk_low = 1'b0; dev_data_low = 1'b0;
      end else begin
        case (dev_state)
          0: begin
            if (ps2_clk_line === 1'b1 && ps2_data_line === 1'b0 && dev_mode != M_SILENT) begin
              dcnt++;
              if (dcnt == 5) begin
                bits = '0; bits[0] = ps2_data_line; dev_bit = 1; dcnt = 0; dev_state = 1;
              end
            end else dcnt = 0;
          end
          1: begin
            dev_clk_low = 1'b1;
            dcnt++;
            if (dcnt == HALF) begin dev_clk_low = 1'b0; dcnt = 0; dev_state = 2; end
          end
          2: begin
            dcnt++;
            if (dcnt == 2 && dev_bit <= 10) bits[dev_bit] = ps2_data_line;
            if (dcnt == HALF / 2 && dev_bit == 10 && dev_mode == M_ACK) dev_data_low = 1'b1;
            if (dcnt == HALF) begin
              dcnt = 0;
              if (dev_bit == 11) dev_state = 3;
              else begin dev_bit++; dev_state = 1; end
            end
          end
          default: begin
            dev_data_low = 1'b0;
            dev_state = 0;
            if (exp_frame.size() == 0) fail_evt("frame_unexpected");
            else chk("frame_bits", 32'(bits), 32'(exp_frame.pop_front()));
          end
        endcase
      end
    end
  end

  // Monitor: accepts, inhibit length, and transfer outcomes.
  initial begin
    logic acc;
    logic prev_cdl;
    int low_cnt, req_cyc;
    out_t e;
    prev_cdl = 1'b0; low_cnt = 0; req_cyc = 0;
    forever begin
      @(negedge clk); #1;
      acc = bus.tx_valid && bus.tx_ready && !rst;
      @(posedge clk); #1;
      if (rst) begin
        prev_cdl = 1'b0; low_cnt = 0;
      end else begin
        if (acc) begin
          n_acc++;
          chk("accept_inhibit", 32'(rx_inhibit), 32'd1);
          chk("accept_clk_low", 32'(clk_drive_low), 32'd1);
          chk("accept_busy", 32'(bus.tx_ready), 32'd0);
        end
        if (clk_drive_low) low_cnt++;
        else if (prev_cdl) begin
          chk("inhibit_len", 32'(low_cnt), 32'(INH));
          chk("start_bit_held", 32'(data_drive_low), 32'd1);
          req_cyc = cyc; low_cnt = 0;
        end
        prev_cdl = clk_drive_low;
        if (bus.tx_done || bus.tx_error) begin
          if (exp_out.size() == 0) fail_evt("outcome_unexpected");
          else begin
            e = exp_out.pop_front();
            chk("outcome_error", 32'(bus.tx_error), 32'(e.is_err));
            chk("outcome_done", 32'(bus.tx_done), 32'(!e.is_err));
            if (e.is_err) chk("timeout_cycles", 32'(cyc - req_cyc), 32'(TO));
            else chk("ack_ok", 32'(bus.tx_ack_ok), 32'(e.ack));
            chk("ready_after", 32'(bus.tx_ready), 32'd1);
            chk("lines_released", 32'({clk_drive_low, data_drive_low}), 32'd0);
            chk("inhibit_dropped", 32'(rx_inhibit), 32'd0);
            $display("txn: outcome done=%0b err=%0b ack_ok=%0b", bus.tx_done, bus.tx_error, bus.tx_ack_ok);
          end
        end
      end
    end
  end

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_ready"}, 32'(bus.tx_ready), 32'd1);
    chk({tag, "_lines"}, 32'({clk_drive_low, data_drive_low}), 32'd0);
    chk({tag, "_inhibit"}, 32'(rx_inhibit), 32'd0);
    chk({tag, "_pulses"}, 32'({bus.tx_done, bus.tx_error, bus.tx_ack_ok}), 32'd0);
  endtask

  // Watchdog: the run must never hang.
  initial begin
    #(60000 * 10);
    $display("FAIL watchdog: simulation exceeded cycle budget, required completion");
    $fatal(1, "watchdog");
  end

  // Stimulus
  initial begin
    logic [7:0] b;
    int m, w;
    bus.tx_valid = 1'b0;
    bus.tx_data  = 8'h00;
    #2 rst = 1'b1;
    repeat (3) @(negedge clk);
    #1 chk_reset_vals("reset");
    @(negedge clk);
    rst = 1'b0;

    // 0xED with ack
    dev_mode = M_ACK;
    expect_xfer(8'hED, M_ACK); send(8'hED, 1); wait_drain();
    chk("ack_ok_hold_1", 32'(bus.tx_ack_ok), 32'd1);

    // back-to-back 0x00 / 0xFF, valid ignored while busy, then 0x01
    expect_xfer(8'h00, M_ACK); send(8'h00, 1);
    repeat (5) begin bus.tx_data = 8'h55; bus.tx_valid = 1'b1; @(negedge clk); end
    bus.tx_valid = 1'b0;
    expect_xfer(8'hFF, M_ACK); send(8'hFF, 1);
    expect_xfer(8'h01, M_ACK); send(8'h01, 1);
    wait_drain();

    // no ack from device
    dev_mode = M_NACK;
    expect_xfer(8'hF3, M_NACK); send(8'hF3, 1); wait_drain();
    chk("ack_ok_hold_0", 32'(bus.tx_ack_ok), 32'd0);

    // device never clocks -> timeout
    dev_mode = M_SILENT;
    expect_xfer(8'hFF, M_SILENT); send(8'hFF, 1); wait_drain();

    // reset in the middle of data bit 4, then a clean 0xF4
    dev_mode = M_ACK;
    expect_xfer(8'hA5, M_ACK); send(8'hA5, 1);
    w = 0;
    while (!(dev_state == 2 && dev_bit == 5) && w < 2000) begin @(negedge clk); w++; end
    if (w >= 2000) fail_evt("bit4_wait_timeout");
    @(negedge clk); #2 rst = 1'b1;
    #1 chk_reset_vals("midreset");
    exp_out.delete(); exp_frame.delete();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    expect_xfer(8'hF4, M_ACK); send(8'hF4, 1); wait_drain();

    // tx_valid held three cycles -> one transfer
    expect_xfer(8'h3C, M_ACK); send(8'h3C, 3); wait_drain();

    // randomized bytes and ack behaviour
    for (int i = 0; i < 8; i++) begin
      b = 8'($urandom);
      m = ($urandom_range(0, 3) == 0) ? M_NACK : M_ACK;
      dev_mode = m;
      expect_xfer(b, m); send(b, 1); wait_drain();
      repeat ($urandom_range(0, 10)) @(negedge clk);
    end

    chk("accept_count", 32'(n_acc), 32'(exp_acc));
    chk("scoreboard_empty", 32'(exp_out.size() + exp_frame.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
